i2c_bit_timer: RTL and testbench
================================

// Module: i2c_bit_timer
// PURPOSE
//  Slave-side I2C bit/frame timer. Counts SCL edges after a START to frame each
//  8-bit transfer plus its ACK slot. Produces the single-cycle strobes the main
//  controller FSM waits on: byte_received, ack_prep, ack_check, ack_done.
//  Sits between the SCL/SDA edge detector (upstream) and the controller (downstream).
// PARAMETERS
//  BITS_PER_FRAME  8  data bits per frame before the ACK slot (legal range 1..15)
// PORTS
//  clk            in   1  system clock, all logic rising-edge
//  n_rst          in   1  synchronous active-low reset
//  start_found    in   1  1-cycle pulse: START or repeated START detected
//  stop_found     in   1  1-cycle pulse: STOP detected
//  scl_rise       in   1  1-cycle pulse: synchronized SCL rising edge
//  scl_fall       in   1  1-cycle pulse: synchronized SCL falling edge
//  shift_strobe   out  1  1-cycle pulse: sample/shift one data bit (SCL rise in DATA)
//  byte_received  out  1  1-cycle pulse: last data bit of the frame sampled
//  ack_prep       out  1  1-cycle pulse: SCL fell after last data bit; ACK slot opens
//  ack_check      out  1  1-cycle pulse: SCL rose in ACK slot; sample master ACK on SDA
//  ack_done       out  1  1-cycle pulse: SCL fell ending ACK slot; next frame begins
//  bit_cnt        out  4  data bits sampled in the current frame (0..BITS_PER_FRAME)
//  frame_active   out  1  high from START until STOP or reset
// BEHAVIOUR
//  Reset (n_rst=0 at clk edge): state=IDLE, bit_cnt=0, all outputs 0.
//  All outputs registered: each pulse asserts exactly 1 cycle after its input edge.
//  FSM states: IDLE, DATA, ACK_WAIT_RISE, ACK_WAIT_FALL.
//   IDLE: scl_rise/scl_fall ignored. start_found -> DATA, bit_cnt=0.
//   DATA: scl_fall ignored. scl_rise -> shift_strobe, bit_cnt+1. When the
//     increment reaches BITS_PER_FRAME: byte_received in the same cycle as
//     shift_strobe, -> ACK_WAIT_RISE... via first waiting for scl_fall:
//     next scl_fall -> ack_prep, -> ACK_WAIT_RISE.
//   ACK_WAIT_RISE: scl_rise -> ack_check, -> ACK_WAIT_FALL.
//   ACK_WAIT_FALL: scl_fall -> ack_done, bit_cnt=0, -> DATA.
//  bit_cnt holds BITS_PER_FRAME through the ACK slot; never wraps past it.
//  frame_active = (state != IDLE).
//  Priority in one cycle: stop_found > start_found > scl edges.
//   stop_found in any state -> IDLE, bit_cnt=0, no strobe that cycle.
//   start_found in any non-IDLE state (repeated START) -> DATA, bit_cnt=0,
//     any edge in that cycle ignored.
//  scl_rise and scl_fall together (illegal upstream): scl_rise processed only.
//  Partial frame aborted by STOP/START produces no byte_received.
//  Strobes mutually exclusive except shift_strobe+byte_received on last bit.
//  Controller clock-stretch holds SCL low; timer simply waits, no timeout.
// TESTING
//  1 Reset: n_rst=0 two cycles with edges toggling -> all outputs 0, state IDLE.
//  2 START, 8 rise/fall pairs, 1 ACK pair -> 8 shift_strobe, byte_received with
//    8th, ack_prep on 9th fall, ack_check on 9th rise, ack_done on 10th fall.
//  3 Two back-to-back frames -> bit_cnt 0..8 twice, ack_done resets bit_cnt to 0.
//  4 STOP after 5 bits -> IDLE next cycle, bit_cnt=0, no byte_received/ack_prep.
//  5 Repeated START during ACK_WAIT_FALL -> DATA, bit_cnt=0, no ack_done.
//  6 start_found+stop_found+scl_rise same cycle -> IDLE, no strobes.

Source files
------------

// File: rtl/i2c_bit_timer.sv
// Slave-side I2C bit/frame timer: frames each data byte plus its ACK slot from
// synchronized SCL edges and emits single-cycle strobes for the controller FSM.
module i2c_bit_timer #(
   parameter int unsigned BITS_PER_FRAME = 8
) (
   input  logic       i_clk,
   input  logic       i_n_rst,
   input  logic       i_start_found,
   input  logic       i_stop_found,
   input  logic       i_scl_rise,
   input  logic       i_scl_fall,
   output logic       o_shift_strobe,
   output logic       o_byte_received,
   output logic       o_ack_prep,
   output logic       o_ack_check,
   output logic       o_ack_done,
   output logic [3:0] o_bit_cnt,
   output logic       o_frame_active
);

   localparam logic [3:0] LP_BPF = 4'(BITS_PER_FRAME);

   typedef enum logic [1:0] {
      ST_IDLE          = 2'd0,
      ST_DATA          = 2'd1,
      ST_ACK_WAIT_RISE = 2'd2,
      ST_ACK_WAIT_FALL = 2'd3
   } state_t;

   state_t     r_state;
   logic       r_shift_strobe;
   logic       r_byte_received;
   logic       r_ack_prep;
   logic       r_ack_check;
   logic       r_ack_done;
   logic [3:0] r_bit_cnt;
   logic       r_frame_active;
   logic [3:0] w_bit_cnt_inc;

   assign w_bit_cnt_inc = r_bit_cnt + 4'd1;

   // Frame FSM; stop beats start beats SCL edges, and a lone rise beats a simultaneous fall.
   always_ff @(posedge i_clk) begin
      if (!i_n_rst) begin
         r_state         <= ST_IDLE;
         r_shift_strobe  <= 1'b0;
         r_byte_received <= 1'b0;
         r_ack_prep      <= 1'b0;
         r_ack_check     <= 1'b0;
         r_ack_done      <= 1'b0;
         r_bit_cnt       <= 4'd0;
         r_frame_active  <= 1'b0;
      end else begin
         r_shift_strobe  <= 1'b0;
         r_byte_received <= 1'b0;
         r_ack_prep      <= 1'b0;
         r_ack_check     <= 1'b0;
         r_ack_done      <= 1'b0;
         if (i_stop_found) begin
            r_state        <= ST_IDLE;
            r_bit_cnt      <= 4'd0;
            r_frame_active <= 1'b0;
         end else if (i_start_found) begin
            r_state        <= ST_DATA;
            r_bit_cnt      <= 4'd0;
            r_frame_active <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_IDLE;
               end
               ST_DATA: begin
                  // A full count means the last bit is in; wait here for SCL low to open ACK.
                  if (r_bit_cnt == LP_BPF) begin
                     if (i_scl_fall && !i_scl_rise) begin
                        r_ack_prep <= 1'b1;
                        r_state    <= ST_ACK_WAIT_RISE;
                     end else begin
                        r_state <= ST_DATA;
                     end
                  end else if (i_scl_rise) begin
                     r_shift_strobe  <= 1'b1;
                     r_bit_cnt       <= w_bit_cnt_inc;
                     r_byte_received <= (w_bit_cnt_inc == LP_BPF);
                  end else begin
                     r_state <= ST_DATA;
                  end
               end
               ST_ACK_WAIT_RISE: begin
                  if (i_scl_rise) begin
                     r_ack_check <= 1'b1;
                     r_state     <= ST_ACK_WAIT_FALL;
                  end else begin
                     r_state <= ST_ACK_WAIT_RISE;
                  end
               end
               ST_ACK_WAIT_FALL: begin
                  if (i_scl_fall && !i_scl_rise) begin
                     r_ack_done <= 1'b1;
                     r_bit_cnt  <= 4'd0;
                     r_state    <= ST_DATA;
                  end else begin
                     r_state <= ST_ACK_WAIT_FALL;
                  end
               end
               default: begin
                  r_state        <= ST_IDLE;
                  r_bit_cnt      <= 4'd0;
                  r_frame_active <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_shift_strobe  = r_shift_strobe;
   assign o_byte_received = r_byte_received;
   assign o_ack_prep      = r_ack_prep;
   assign o_ack_check     = r_ack_check;
   assign o_ack_done      = r_ack_done;
   assign o_bit_cnt       = r_bit_cnt;
   assign o_frame_active  = r_frame_active;

endmodule

// File: tb/tb_i2c_bit_timer.sv
// Directed-vector bench for i2c_bit_timer: stimulus pushes hand-computed expected
// outputs into a queue; an independent monitor pops and compares each cycle.
module tb_i2c_bit_timer;

   localparam int BPF = 8;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       start_found = 1'b0;
   logic       stop_found = 1'b0;
   logic       scl_rise = 1'b0;
   logic       scl_fall = 1'b0;
   logic       shift_strobe, byte_received, ack_prep, ack_check, ack_done;
   logic [3:0] bit_cnt;
   logic       frame_active;

   typedef struct {
      int         due;
      string      name;
      logic [4:0] strb;
      logic [3:0] cnt;
      logic       act;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   i2c_bit_timer #(.BITS_PER_FRAME(BPF)) dut (
      .i_clk           (clk),
      .i_n_rst         (n_rst),
      .i_start_found   (start_found),
      .i_stop_found    (stop_found),
      .i_scl_rise      (scl_rise),
      .i_scl_fall      (scl_fall),
      .o_shift_strobe  (shift_strobe),
      .o_byte_received (byte_received),
      .o_ack_prep      (ack_prep),
      .o_ack_check     (ack_check),
      .o_ack_done      (ack_done),
      .o_bit_cnt       (bit_cnt),
      .o_frame_active  (frame_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: outputs settle just after the edge; compare against the entry due this cycle.
   initial begin
      logic [4:0] act_strb;
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            act_strb = {shift_strobe, byte_received, ack_prep, ack_check, ack_done};
            n_cmp++;
            if (e.due != cyc || act_strb !== e.strb || bit_cnt !== e.cnt || frame_active !== e.act) begin
               n_bad++;
               $display("FAIL %s @cyc %0d: got strb=%b cnt=%0d act=%b, expected strb=%b cnt=%0d act=%b (due %0d)",
                        e.name, cyc, act_strb, bit_cnt, frame_active, e.strb, e.cnt, e.act, e.due);
            end
         end
      end
   end

   // Strobe encoding: {shift, byte_received, ack_prep, ack_check, ack_done}
   task automatic step(input string nm, input logic rn, input logic st, input logic sp,
                       input logic r, input logic f,
                       input logic [4:0] es, input logic [3:0] ec, input logic ea);
      exp_t e;
      @(posedge clk);
      #1;
      n_rst = rn; start_found = st; stop_found = sp; scl_rise = r; scl_fall = f;
      e.due = cyc + 1; e.name = nm; e.strb = es; e.cnt = ec; e.act = ea;
      exp_q.push_back(e);
   endtask

   // n data bits as rise/fall pairs, starting from bit_cnt = 0 in DATA.
   task automatic data_bits(input string nm, input int n);
      for (int i = 1; i <= n; i++) begin
         step(nm, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (i == BPF) ? 5'b11000 : 5'b10000, 4'(i), 1'b1);
         step(nm, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (i == BPF) ? 5'b00100 : 5'b00000, 4'(i), 1'b1);
      end
   endtask

   task automatic ack_slot(input string nm);
      step({nm, "_chk"}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00010, 4'd8, 1'b1);
      step({nm, "_done"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00001, 4'd0, 1'b1);
   endtask

   initial begin
      // 1: reset held with edges toggling
      step("rst0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b0, 4'd0, 1'b0);
      step("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0, 4'd0, 1'b0);
      step("idle_edges", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'b0, 4'd0, 1'b0);
      // 2+3: START, first fall, two back-to-back frames with a stretch in the middle
      step("start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 4'd0, 1'b1);
      step("fall1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0, 4'd0, 1'b1);
      data_bits("f1", 4);
      step("stretch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 4'd4, 1'b1);
      step("stretch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 4'd4, 1'b1);
      for (int i = 5; i <= BPF; i++) begin
         step("f1b", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (i == BPF) ? 5'b11000 : 5'b10000, 4'(i), 1'b1);
         step("f1b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (i == BPF) ? 5'b00100 : 5'b00000, 4'(i), 1'b1);
      end
      ack_slot("f1");
      data_bits("f2", BPF);
      step("ackwait_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 4'd8, 1'b1);
      ack_slot("f2");
      // 4: STOP after 5 bits
      data_bits("f3", 5);
      step("stop5", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'b0, 4'd0, 1'b0);
      step("post_stop_rise", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b0, 4'd0, 1'b0);
      // 5: repeated START in ACK_WAIT_FALL, plus no-wrap and rise+fall handling
      step("start2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 4'd0, 1'b1);
      step("both_data", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'b10000, 4'd1, 1'b1);
      step("fall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0, 4'd1, 1'b1);
      for (int i = 2; i <= BPF; i++) begin
         step("f4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (i == BPF) ? 5'b11000 : 5'b10000, 4'(i), 1'b1);
      end
      step("nowrap_rise", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b0, 4'd8, 1'b1);
      step("both_full", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'b0, 4'd8, 1'b1);
      step("prep", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00100, 4'd8, 1'b1);
      step("chk", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00010, 4'd8, 1'b1);
      step("both_ackfall", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'b0, 4'd8, 1'b1);
      step("rstart_ack", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b0, 4'd0, 1'b1);
      step("after_rstart", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10000, 4'd1, 1'b1);
      // 6: start+stop+rise together, from DATA and from IDLE
      step("ssr_data", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, 4'd0, 1'b0);
      step("ssr_idle", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, 4'd0, 1'b0);
      step("quiet", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 4'd0, 1'b0);
      step("quiet", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 4'd0, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
